// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - MIPS ID stage: register file, control decode, load-use hazard, ID/EX register
//
// Optional feature macro: DECODE_BYPASS_EN (write-through of wb_data to same-cycle ID reads)
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_valid, if_inst, if_pc    IF/ID contents (if_pc is PC+4)
//   id_stall                    hold PC and IF/ID this cycle (combinational)
//   flush                       kill the instruction currently in ID
//   ex_ready                    EX can accept a new ID/EX entry
//   wb_we, wb_addr, wb_data     register file write port
//   ex_valid, ex_ctrl, ex_illegal, ex_data1, ex_data2, ex_rs, ex_rt, ex_rd,
//   ex_imm, ex_shamt, ex_funct, ex_jaddr, ex_pc   registered ID/EX entry
//   ex_ctrl = {regWrite,memToReg,memRead,memWrite,branch_eq,branch_ne,jump,aluSrc,aluOp[1:0]}

module decode_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        if_valid,
    input  logic [31:0]                 if_inst,
    input  logic [XLEN-1:0]             if_pc,
    output logic                        id_stall,
    input  logic                        flush,
    input  logic                        ex_ready,
    input  logic                        wb_we,
    input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
    input  logic [XLEN-1:0]             wb_data,
    output logic                        ex_valid,
    output logic [9:0]                  ex_ctrl,
    output logic                        ex_illegal,
    output logic [XLEN-1:0]             ex_data1,
    output logic [XLEN-1:0]             ex_data2,
    output logic [$clog2(NUM_REGS)-1:0] ex_rs,
    output logic [$clog2(NUM_REGS)-1:0] ex_rt,
    output logic [$clog2(NUM_REGS)-1:0] ex_rd,
    output logic [XLEN-1:0]             ex_imm,
    output logic [4:0]                  ex_shamt,
    output logic [5:0]                  ex_funct,
    output logic [XLEN-1:0]             ex_jaddr,
    output logic [XLEN-1:0]             ex_pc
);

    localparam int AW = $clog2(NUM_REGS);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam int CTRL_MEMREAD = 7;

    logic [5:0]      opcode;
    logic [AW-1:0]   rs_addr;
    logic [AW-1:0]   rt_addr;
    logic [AW-1:0]   rd_field;
    logic [9:0]      dec_ctrl;
    logic            dec_illegal;
    logic            dec_is_r;
    logic            dec_uses_rt;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            hz;
    logic [XLEN-1:0] regs [NUM_REGS];

    assign opcode   = if_inst[31:26];
    assign rs_addr  = if_inst[21 +: AW];
    assign rt_addr  = if_inst[16 +: AW];
    assign rd_field = if_inst[11 +: AW];

    // Register file: reg 0 is never written and always reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rd1 = (rs_addr == '0) ? '0 : regs[rs_addr];
        rd2 = (rt_addr == '0) ? '0 : regs[rt_addr];
`ifdef DECODE_BYPASS_EN
        if (wb_we && (wb_addr == rs_addr) && (rs_addr != '0)) rd1 = wb_data;
        if (wb_we && (wb_addr == rt_addr) && (rt_addr != '0)) rd2 = wb_data;
`endif
    end

    // Main control decode. dec_uses_rt marks opcodes that read rt as a source,
    // which is what makes a pending load into rt a hazard.
    always_comb begin
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        dec_is_r    = 1'b0;
        dec_uses_rt = 1'b0;
        case (opcode)
            OP_R:    begin dec_ctrl = 10'b10_0000_0010; dec_is_r = 1'b1; dec_uses_rt = 1'b1; end
            OP_LW:   dec_ctrl = 10'b11_1000_0100;
            OP_SW:   begin dec_ctrl = 10'b00_0100_0100; dec_uses_rt = 1'b1; end
            OP_BEQ:  begin dec_ctrl = 10'b00_0010_0001; dec_uses_rt = 1'b1; end
            OP_BNE:  begin dec_ctrl = 10'b00_0001_0001; dec_uses_rt = 1'b1; end
            OP_ADDI: dec_ctrl = 10'b10_0000_0100;
            OP_J:    dec_ctrl = 10'b00_0000_1000;
            default: dec_illegal = 1'b1;
        endcase
    end

    assign hz = if_valid && ex_valid && ex_ctrl[CTRL_MEMREAD] && (ex_rt != '0) &&
                ((ex_rt == rs_addr) || ((ex_rt == rt_addr) && dec_uses_rt));

    // Gated by rst_n so fetch is never held while the stage is in reset.
    assign id_stall = rst_n && (!ex_ready || (hz && !flush));

    // ID/EX register. Bubbles only clear valid/ctrl/illegal; data fields are stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_illegal <= 1'b0;
            ex_data1   <= '0;
            ex_data2   <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_imm     <= '0;
            ex_shamt   <= '0;
            ex_funct   <= '0;
            ex_jaddr   <= '0;
            ex_pc      <= '0;
        end else if (ex_ready) begin
            if (flush || hz || !if_valid) begin
                ex_valid   <= 1'b0;
                ex_ctrl    <= '0;
                ex_illegal <= 1'b0;
            end else begin
                ex_valid   <= 1'b1;
                ex_ctrl    <= dec_ctrl;
                ex_illegal <= dec_illegal;
                ex_data1   <= rd1;
                ex_data2   <= rd2;
                ex_rs      <= rs_addr;
                ex_rt      <= rt_addr;
                ex_rd      <= dec_is_r ? rd_field : rt_addr;
                ex_imm     <= {{(XLEN-16){if_inst[15]}}, if_inst[15:0]};
                ex_shamt   <= if_inst[10:6];
                ex_funct   <= if_inst[5:0];
                ex_jaddr   <= {if_pc[XLEN-1:28], if_inst[25:0], 2'b00};
                ex_pc      <= if_pc;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - self-checking bench for decode_stage_pipe

module tb_decode_stage_pipe;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int AW       = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_valid;
    logic [31:0]     if_inst;
    logic [XLEN-1:0] if_pc;
    logic            id_stall;
    logic            flush;
    logic            ex_ready;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            ex_valid;
    logic [9:0]      ex_ctrl;
    logic            ex_illegal;
    logic [XLEN-1:0] ex_data1, ex_data2, ex_imm, ex_jaddr, ex_pc;
    logic [AW-1:0]   ex_rs, ex_rt, ex_rd;
    logic [4:0]      ex_shamt;
    logic [5:0]      ex_funct;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    decode_stage_pipe #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_stall(id_stall), .flush(flush), .ex_ready(ex_ready),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_illegal(ex_illegal),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_imm(ex_imm), .ex_shamt(ex_shamt), .ex_funct(ex_funct), .ex_jaddr(ex_jaddr), .ex_pc(ex_pc)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [9:0]  ctrl;
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        chk_j;
        logic [31:0] jaddr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        step();
        wb_we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        if_valid = 1'b1; if_inst = inst; if_pc = pc;
    endtask

    initial begin
        // inst, pc, ctrl, ill, rd, imm, d1, d2, chk_j, jaddr
        vecs[0] = '{32'h012B5020, 32'h00400004, 10'h202, 1'b0, 5'd10, 32'h00005020, 32'h11,  32'h33, 1'b0, 32'h0};
        vecs[1] = '{32'h8D09FFFC, 32'h00400008, 10'h384, 1'b0, 5'd9,  32'hFFFFFFFC, 32'h100, 32'h11, 1'b0, 32'h0};
        vecs[2] = '{32'hAD0B0008, 32'h0040000C, 10'h044, 1'b0, 5'd11, 32'h00000008, 32'h100, 32'h33, 1'b0, 32'h0};
        vecs[3] = '{32'h110B0010, 32'h00400010, 10'h021, 1'b0, 5'd11, 32'h00000010, 32'h100, 32'h33, 1'b0, 32'h0};
        vecs[4] = '{32'h150B0010, 32'h00400014, 10'h011, 1'b0, 5'd11, 32'h00000010, 32'h100, 32'h33, 1'b0, 32'h0};
        vecs[5] = '{32'h210A0005, 32'h00400018, 10'h204, 1'b0, 5'd10, 32'h00000005, 32'h100, 32'h0,  1'b0, 32'h0};
        vecs[6] = '{32'h08123456, 32'hA0000004, 10'h008, 1'b0, 5'd18, 32'h00003456, 32'h0,   32'h0,  1'b1, 32'hA048D158};
        vecs[7] = '{32'hFC000000, 32'h00400020, 10'h000, 1'b1, 5'd0,  32'h00000000, 32'h0,   32'h0,  1'b0, 32'h0};

        rst_n = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0; flush = 1'b0;
        ex_ready = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        step(); step();
        check("reset_valid", {31'd0, ex_valid}, 32'd0);
        check("reset_ctrl", {22'd0, ex_ctrl}, 32'd0);
        check("reset_data1", ex_data1, 32'd0);
        check("reset_pc", ex_pc, 32'd0);
        check("reset_stall", {31'd0, id_stall}, 32'd0);
        rst_n = 1'b1; ex_ready = 1'b1;

        wb_write(5'd8, 32'h100);
        wb_write(5'd9, 32'h11);
        wb_write(5'd11, 32'h33);
        wb_write(5'd5, 32'h55);

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].inst, vecs[i].pc);
            #1;
            check($sformatf("v%0d_stall", i), {31'd0, id_stall}, 32'd0);
            step();
            check($sformatf("v%0d_valid", i), {31'd0, ex_valid}, 32'd1);
            check($sformatf("v%0d_ctrl", i), {22'd0, ex_ctrl}, {22'd0, vecs[i].ctrl});
            check($sformatf("v%0d_illegal", i), {31'd0, ex_illegal}, {31'd0, vecs[i].ill});
            check($sformatf("v%0d_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].rd});
            check($sformatf("v%0d_imm", i), ex_imm, vecs[i].imm);
            check($sformatf("v%0d_data1", i), ex_data1, vecs[i].d1);
            check($sformatf("v%0d_data2", i), ex_data2, vecs[i].d2);
            check($sformatf("v%0d_pc", i), ex_pc, vecs[i].pc);
            if (vecs[i].chk_j) check($sformatf("v%0d_jaddr", i), ex_jaddr, vecs[i].jaddr);
        end
        if_valid = 1'b0;
        step();
        check("idle_bubble_valid", {31'd0, ex_valid}, 32'd0);

        // load-use: lw $t1,0($t0) then add $t2,$t1,$t3
        issue(32'h8D090000, 32'h00400100);
        step();
        check("lu_lw_ctrl", {22'd0, ex_ctrl}, 32'h384);
        issue(32'h012B5020, 32'h00400104);
        #1;
        check("lu_stall", {31'd0, id_stall}, 32'd1);
        step();
        check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        check("lu_bubble_ctrl", {22'd0, ex_ctrl}, 32'd0);
        check("lu_stall_released", {31'd0, id_stall}, 32'd0);
        step();
        check("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        check("lu_add_ctrl", {22'd0, ex_ctrl}, 32'h202);

        // lw $t1 then addi $t1,$t0,5: rt is a destination, no stall
        issue(32'h8D090000, 32'h00400200);
        step();
        issue(32'h21090005, 32'h00400204);
        #1;
        check("noh_stall", {31'd0, id_stall}, 32'd0);
        step();
        check("noh_valid", {31'd0, ex_valid}, 32'd1);
        check("noh_ctrl", {22'd0, ex_ctrl}, 32'h204);
        check("noh_rd", {27'd0, ex_rd}, 32'd9);

        // same-cycle write-back and read of $5
        issue(32'h00A05020, 32'h00400300);
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        step();
        wb_we = 1'b0;
`ifdef DECODE_BYPASS_EN
        check("bypass_same_cycle", ex_data1, 32'hDEADBEEF);
`else
        check("bypass_same_cycle", ex_data1, 32'h55);
`endif
        step();
        check("bypass_next_cycle", ex_data1, 32'hDEADBEEF);

        // flush beats load-use hazard
        issue(32'h8D090000, 32'h00400400);
        step();
        issue(32'h012B5020, 32'h00400404);
        flush = 1'b1;
        #1;
        check("flush_hz_stall", {31'd0, id_stall}, 32'd0);
        step();
        flush = 1'b0;
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_ctrl", {22'd0, ex_ctrl}, 32'd0);

        // back-pressure: entry frozen for 3 cycles, flush while held leaves it alone
        issue(32'hAD0B0008, 32'h00400500);
        step();
        check("bp_load_ctrl", {22'd0, ex_ctrl}, 32'h044);
        issue(32'h210A0005, 32'h00400504);
        ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            flush = (k == 1);
            #1;
            check($sformatf("bp%0d_stall", k), {31'd0, id_stall}, 32'd1);
            step();
            check($sformatf("bp%0d_valid", k), {31'd0, ex_valid}, 32'd1);
            check($sformatf("bp%0d_ctrl", k), {22'd0, ex_ctrl}, 32'h044);
            check($sformatf("bp%0d_imm", k), ex_imm, 32'h8);
        end
        flush = 1'b0; ex_ready = 1'b1;
        #1;
        check("bp_release_stall", {31'd0, id_stall}, 32'd0);
        step();
        check("bp_release_ctrl", {22'd0, ex_ctrl}, 32'h204);
        check("bp_release_imm", ex_imm, 32'h5);

        // write to $0 is dropped
        wb_write(5'd0, 32'hFFFFFFFF);
        issue(32'h00005020, 32'h00400600);
        step();
        check("r0_data1", ex_data1, 32'd0);
        check("r0_data2", ex_data2, 32'd0);

        // asynchronous reset mid-run
        issue(32'hAD0B0008, 32'h00400700);
        step();
        check("mid_pre_valid", {31'd0, ex_valid}, 32'd1);
        #2;
        rst_n = 1'b0; ex_ready = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
        check("mid_rst_ctrl", {22'd0, ex_ctrl}, 32'd0);
        check("mid_rst_stall", {31'd0, id_stall}, 32'd0);
        step();
        rst_n = 1'b1; ex_ready = 1'b1;
        issue(32'h01095020, 32'h00400800);
        step();
        check("mid_post_valid", {31'd0, ex_valid}, 32'd1);
        check("mid_post_data1", ex_data1, 32'd0);
        check("mid_post_data2", ex_data2, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
